ram_port_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 16x8 program/data RAM between the CPU memory path and an external program loader. The CPU path is the MAR-addressed fetch/operand read. The loader is a host or debug port used for writes and readback. The arbiter sits between the MAR/IR/A-register side and the RAM array. It serialises accesses, drives the RAM control strobes, and returns read data to the winning requester through a registered holding register.

---
 rtl/ram_port_arbiter_if.sv | 54 +++++
 rtl/ram_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - CPU, loader and RAM-side signals of ram_port_arbiter
// ldr_lock exists only when RAM_ARB_LOCK_EN is defined.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
`ifdef RAM_ARB_LOCK_EN
  logic              ldr_lock;
`endif
  logic              ldr_gnt;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_rvalid;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_addr,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
`ifdef RAM_ARB_LOCK_EN
    input  ldr_lock,
`endif
    input  ram_rdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    output ldr_gnt, ldr_rdata, ldr_rvalid,
    output ram_addr, ram_wdata, ram_we, ram_re, busy
  );

  modport master (
    output cpu_req, cpu_addr,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
`ifdef RAM_ARB_LOCK_EN
    output ldr_lock,
`endif
    output ram_rdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    input  ldr_gnt, ldr_rdata, ldr_rvalid,
    input  ram_addr, ram_wdata, ram_we, ram_re, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - CPU/loader arbiter for the shared single-port program/data RAM
// Define RAM_ARB_LOCK_EN to build the loader bus lock.
module ram_port_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               reset,
  ram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              ldr_gnt_q, ldr_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              ldr_rvalid_q, ldr_rvalid_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
  // Port served by the latest ISSUE (0 = CPU, 1 = loader) and whether it wrote.
  logic              served_ldr_q, served_ldr_d;
  logic              served_we_q, served_we_d;
`ifdef RAM_ARB_LOCK_EN
  logic              lock_q, lock_d;
`endif

  logic arb_now, lock_hold, cpu_elig, ldr_elig, cpu_win, ldr_win;

  always_comb begin
    arb_now   = (state_q == IDLE) || (state_q == CAPTURE);
`ifdef RAM_ARB_LOCK_EN
    lock_hold = lock_q && bus.ldr_lock;
`else
    lock_hold = 1'b0;
`endif
    // The mask only bites at the CAPTURE decision; a held lock exempts the loader.
    cpu_elig = bus.cpu_req && !lock_hold && !((state_q == CAPTURE) && !served_ldr_q);
    ldr_elig = bus.ldr_req && !((state_q == CAPTURE) && served_ldr_q && !lock_hold);
    cpu_win  = arb_now && cpu_elig;
    ldr_win  = arb_now && !cpu_elig && ldr_elig;
  end

  always_comb begin
    state_d      = state_q;
    cpu_gnt_d    = 1'b0;
    ldr_gnt_d    = 1'b0;
    cpu_rvalid_d = 1'b0;
    ldr_rvalid_d = 1'b0;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;
    served_ldr_d = served_ldr_q;
    served_we_d  = served_we_q;

    case (state_q)
      ISSUE:   state_d = CAPTURE;
      IDLE,
      CAPTURE: state_d = (cpu_win || ldr_win) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q == CAPTURE) && !served_we_q) begin
      if (served_ldr_q) begin
        ldr_rvalid_d = 1'b1;
        ldr_rdata_d  = bus.ram_rdata;
      end else begin
        cpu_rvalid_d = 1'b1;
        cpu_rdata_d  = bus.ram_rdata;
      end
    end

    if (cpu_win) begin
      cpu_gnt_d    = 1'b1;
      ram_re_d     = 1'b1;
      ram_addr_d   = bus.cpu_addr;
      served_ldr_d = 1'b0;
      served_we_d  = 1'b0;
    end else if (ldr_win) begin
      ldr_gnt_d    = 1'b1;
      ram_we_d     = bus.ldr_we;
      ram_re_d     = !bus.ldr_we;
      ram_addr_d   = bus.ldr_addr;
      served_ldr_d = 1'b1;
      served_we_d  = bus.ldr_we;
      if (bus.ldr_we) begin
        ram_wdata_d = bus.ldr_wdata;
      end
    end

    busy_d = (state_d != IDLE);

`ifdef RAM_ARB_LOCK_EN
    lock_d = lock_q;
    if (arb_now) begin
      if (!bus.ldr_lock) begin
        lock_d = 1'b0;
      end else if (ldr_win) begin
        lock_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      busy_q       <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
      served_ldr_q <= 1'b0;
      served_we_q  <= 1'b0;
`ifdef RAM_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ldr_gnt_q    <= ldr_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      busy_q       <= busy_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
      served_ldr_q <= served_ldr_d;
      served_we_q  <= served_we_d;
`ifdef RAM_ARB_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.ldr_gnt    = ldr_gnt_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ldr_rvalid = ldr_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ldr_rdata  = ldr_rdata_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_re     = ram_re_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed and randomized checks for ram_port_arbiter
// Lock checks are built when RAM_ARB_LOCK_EN is defined.
module tb_ram_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural RAM with a backdoor for preloading.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] model_mem [16];
  logic          bk_we = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_data = '0;

  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bk_addr = a;
    bk_data = d;
    bk_we   = 1'b1;
    tick();
    bk_we   = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_ctl"}, 32'({bus.cpu_gnt, bus.ldr_gnt, bus.cpu_rvalid, bus.ldr_rvalid,
                                 bus.ram_we, bus.ram_re, bus.busy}), 32'h0);
    check_eq({tag, "_data"}, 32'({bus.ram_addr, bus.ram_wdata, bus.cpu_rdata, bus.ldr_rdata}), 32'h0);
  endtask

  logic          c_act, l_act, l_wr;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] l_data;
  int            c_start, l_start, last_gnt, last_c, last_l, w, pc;
  logic [DW-1:0] cq[$], lq[$];
  int            cc[$], lc[$];
  logic [1:0]    exp_g, exp_v;
  logic          seen;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    bus.cpu_req = 0; bus.cpu_addr = '0;
    bus.ldr_req = 0; bus.ldr_we = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
`ifdef RAM_ARB_LOCK_EN
    bus.ldr_lock = 0;
`endif
    #2 reset = 1'b0;
    #1 check_reset_state("reset_init");

    for (int i = 0; i < 16; i++) begin
      case (i)
        3:       poke(4'(i), 8'h00);
        5:       poke(4'(i), 8'h55);
        9:       poke(4'(i), 8'h01);
        10:      poke(4'(i), 8'h0B);
        default: poke(4'(i), 8'($urandom));
      endcase
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("idle_busy", 32'(bus.busy), 32'h0);
    end

    // CPU read of address 9: gnt one cycle after the request edge, rvalid two later.
    bus.cpu_req = 1; bus.cpu_addr = 4'd9;
    tick();
    check_eq("rd_gnt", 32'({bus.cpu_gnt, bus.ram_re, bus.ram_we, bus.busy}), 32'b1101);
    check_eq("rd_addr", 32'(bus.ram_addr), 32'd9);
    bus.cpu_req = 0;
    tick();
    check_eq("rd_e1", 32'({bus.cpu_gnt, bus.ram_re, bus.cpu_rvalid}), 32'h0);
    tick();
    check_eq("rd_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    check_eq("rd_rdata", 32'(bus.cpu_rdata), 32'h01);
    tick();
    check_eq("rd_after", 32'({bus.cpu_rvalid, bus.busy}), 32'h0);
    check_eq("rd_hold", 32'(bus.cpu_rdata), 32'h01);

    // Loader write 0x79 to address 0, then CPU reads it back.
    bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 4'd0; bus.ldr_wdata = 8'h79;
    tick();
    check_eq("wr_gnt", 32'({bus.ldr_gnt, bus.ram_we, bus.ram_re}), 32'b110);
    check_eq("wr_bus", 32'({bus.ram_addr, bus.ram_wdata}), 32'h079);
    bus.ldr_req = 0;
    model_mem[0] = 8'h79;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | bus.ldr_rvalid;
    end
    check_eq("wr_no_rvalid", 32'(seen), 32'h0);
    bus.cpu_req = 1; bus.cpu_addr = 4'd0;
    tick();
    check_eq("wr_rd_gnt", 32'(bus.cpu_gnt), 32'h1);
    bus.cpu_req = 0;
    tick();
    tick();
    check_eq("wr_rd_rvalid", 32'(bus.cpu_rvalid), 32'h1);
    check_eq("wr_rd_rdata", 32'(bus.cpu_rdata), 32'h79);
    check_eq("wr_ldr_rdata", 32'(bus.ldr_rdata), 32'h0);

    // Asynchronous reset while idle clears the holding registers at once.
    tick();
    #2 reset = 1'b0;
    #1 check_reset_state("rst_idle");
    tick();
    reset = 1'b1;

    // Contention: grants alternate CPU, loader every two cycles starting with CPU.
    bus.cpu_req = 1; bus.cpu_addr = 4'd5;
    bus.ldr_req = 1; bus.ldr_we = 0; bus.ldr_addr = 4'd10;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_g = 2'b00;
      exp_v = 2'b00;
      if (k <= 7 && (k % 2) == 1) exp_g = (((k - 1) / 2) % 2 == 0) ? 2'b10 : 2'b01;
      if (k >= 3 && (k % 2) == 1) exp_v = (((k - 3) / 2) % 2 == 0) ? 2'b10 : 2'b01;
      check_eq($sformatf("cont_gnt_%0d", k), 32'({bus.cpu_gnt, bus.ldr_gnt}), 32'(exp_g));
      check_eq($sformatf("cont_rv_%0d", k), 32'({bus.cpu_rvalid, bus.ldr_rvalid}), 32'(exp_v));
      if (bus.cpu_rvalid) check_eq("cont_cpu_rdata", 32'(bus.cpu_rdata), 32'h55);
      if (bus.ldr_rvalid) check_eq("cont_ldr_rdata", 32'(bus.ldr_rdata), 32'h0B);
      if (k == 8) begin
        bus.cpu_req = 0;
        bus.ldr_req = 0;
      end
    end
    check_eq("cont_final", 32'({bus.cpu_rdata, bus.ldr_rdata}), 32'h550B);
    tick();
    tick();

    // Reset in ISSUE of a loader write: strobe drops before the edge, RAM untouched.
    bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_addr = 4'd3; bus.ldr_wdata = 8'hAA;
    tick();
    check_eq("rst_issue_pre", 32'({bus.ldr_gnt, bus.ram_we}), 32'b11);
    #2 reset = 1'b0;
    bus.ldr_req = 0;
    #1 check_reset_state("rst_issue");
    tick();
    reset = 1'b1;
    check_eq("rst_issue_mem", 32'(mem[3]), 32'h00);

    // Reset in CAPTURE of a CPU read: no rvalid afterwards, busy stays low.
    bus.cpu_req = 1; bus.cpu_addr = 4'd9;
    tick();
    bus.cpu_req = 0;
    tick();
    check_eq("rst_cap_busy", 32'(bus.busy), 32'h1);
    #2 reset = 1'b0;
    #1 check_reset_state("rst_cap");
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_cap_after", 32'({bus.busy, bus.cpu_rvalid}), 32'h0);
    end

`ifdef RAM_ARB_LOCK_EN
    // Locked loader: four writes two cycles apart while the CPU waits.
    bus.ldr_req = 1; bus.ldr_we = 1; bus.ldr_lock = 1;
    bus.ldr_addr = 4'd12; bus.ldr_wdata = 8'hC0;
    tick();
    check_eq("lock_gnt_0", 32'({bus.cpu_gnt, bus.ldr_gnt}), 32'b01);
    model_mem[12] = 8'hC0;
    pc = 1;
    bus.ldr_addr = 4'd13; bus.ldr_wdata = 8'hC1;
    bus.cpu_req = 1; bus.cpu_addr = 4'd12;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = 2'b00;
      if (k <= 6 && (k % 2) == 0) exp_g = 2'b01;
      if (k == 8) exp_g = 2'b10;
      check_eq($sformatf("lock_gnt_%0d", k), 32'({bus.cpu_gnt, bus.ldr_gnt}), 32'(exp_g));
      if (bus.ldr_gnt) begin
        model_mem[bus.ldr_addr] = bus.ldr_wdata;
        pc++;
        bus.ldr_addr = 4'(12 + pc);
        bus.ldr_wdata = 8'(8'hC0 + pc);
        if (pc == 4) begin
          bus.ldr_req = 0;
          bus.ldr_lock = 0;
        end
      end
      if (bus.cpu_gnt) bus.cpu_req = 0;
    end
    tick();
    tick();
    check_eq("lock_cpu_rdata", 32'({bus.cpu_rvalid, bus.cpu_rdata}), 32'h1C0);
    tick();
`endif

    // Randomized traffic against a transaction-level model.
    c_act = 0; l_act = 0; l_wr = 0; c_addr = '0; l_addr = '0; l_data = '0;
    c_start = 0; l_start = 0; last_gnt = -100; last_c = -100; last_l = -100;
    for (int t = 0; t < 600; t++) begin
      tick();
      if (bus.cpu_rvalid) begin
        if (cq.size() == 0) check_eq("rnd_cpu_rv_extra", 32'(bus.cpu_rvalid), 32'h0);
        else begin
          check_eq("rnd_cpu_rdata", 32'(bus.cpu_rdata), 32'(cq.pop_front()));
          check_eq("rnd_cpu_lat", 32'(cyc - cc.pop_front()), 32'd2);
        end
      end
      if (bus.ldr_rvalid) begin
        if (lq.size() == 0) check_eq("rnd_ldr_rv_extra", 32'(bus.ldr_rvalid), 32'h0);
        else begin
          check_eq("rnd_ldr_rdata", 32'(bus.ldr_rdata), 32'(lq.pop_front()));
          check_eq("rnd_ldr_lat", 32'(cyc - lc.pop_front()), 32'd2);
        end
      end
      if (bus.cpu_gnt || bus.ldr_gnt) begin
        check_eq("rnd_one_gnt", 32'(bus.cpu_gnt & bus.ldr_gnt), 32'h0);
        check_eq("rnd_gnt_gap", 32'(cyc - last_gnt >= 2), 32'h1);
        last_gnt = cyc;
      end
      if (bus.cpu_gnt) begin
        if (!c_act) check_eq("rnd_cpu_gnt_unreq", 32'(c_act), 32'h1);
        else begin
          check_eq("rnd_cpu_addr", 32'(bus.ram_addr), 32'(c_addr));
          check_eq("rnd_cpu_strobe", 32'({bus.ram_we, bus.ram_re}), 32'b01);
          w = cyc - c_start;
          check_eq("rnd_cpu_wait", 32'(w >= 1 && w <= 4), 32'h1);
          check_eq("rnd_cpu_gap", 32'(cyc - last_c >= 3), 32'h1);
          cq.push_back(model_mem[c_addr]);
          cc.push_back(cyc);
          c_act = 0;
        end
        last_c = cyc;
      end
      if (bus.ldr_gnt) begin
        if (!l_act) check_eq("rnd_ldr_gnt_unreq", 32'(l_act), 32'h1);
        else begin
          check_eq("rnd_ldr_addr", 32'(bus.ram_addr), 32'(l_addr));
          check_eq("rnd_ldr_strobe", 32'({bus.ram_we, bus.ram_re}), l_wr ? 32'b10 : 32'b01);
          w = cyc - l_start;
          check_eq("rnd_ldr_wait", 32'(w >= 1 && w <= 4), 32'h1);
          check_eq("rnd_ldr_gap", 32'(cyc - last_l >= 3), 32'h1);
          if (l_wr) begin
            check_eq("rnd_ldr_wdata", 32'(bus.ram_wdata), 32'(l_data));
            model_mem[l_addr] = l_data;
          end else begin
            lq.push_back(model_mem[l_addr]);
            lc.push_back(cyc);
          end
          l_act = 0;
        end
        last_l = cyc;
      end
      if (!c_act && t < 560 && $urandom_range(0, 2) != 0) begin
        c_act = 1;
        c_addr = 4'($urandom_range(0, 15));
        c_start = cyc;
      end
      if (!l_act && t < 560 && $urandom_range(0, 1) != 0) begin
        l_act = 1;
        l_wr = 1'($urandom_range(0, 1));
        l_addr = 4'($urandom_range(0, 15));
        l_data = 8'($urandom);
        l_start = cyc;
      end
      bus.cpu_req = c_act; bus.cpu_addr = c_addr;
      bus.ldr_req = l_act; bus.ldr_we = l_wr; bus.ldr_addr = l_addr; bus.ldr_wdata = l_data;
    end
    check_eq("rnd_drain", 32'(cq.size() + lq.size() + int'(c_act) + int'(l_act)), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
